game_sound_sequencer: RTL
=========================

Name: game_sound_sequencer

Overview:
- Parametrised sound-effect engine for the whack-a-mole game. Plays one of NUM_SFX square-wave effects (hit, miss, start, game-over) when the datapath pulses a trigger.
- Each effect has a fixed pitch and duration.
- Feeds the DE1-SoC audio codec output FIFO through its allowed/write handshake.
- Successor to the 2-bit hit/miss sound select: adds any number of effects, durations, priority/preemption, mute and a proper sample stream.

Parameters:
- NUM_SFX, 4, number of effect channels; id 0 has highest priority.
- SAMPLE_W, 24, codec sample width (signed two's complement).
- AMPLITUDE, 24'h100000, positive peak magnitude; must fit in SAMPLE_W-1 bits.
- CNT_W, 16, width of the half-period and duration counters.
- HALF_PERIOD_TABLE, {16'd120,16'd48,16'd96,16'd24}, packed NUM_SFX*CNT_W bits, id 0 in LSBs. Half-period in samples (at 48 kHz: 1 kHz hit, 250 Hz miss, 500 Hz start, 200 Hz game-over).
- DURATION_TABLE, {16'd24000,16'd2400,16'd9600,16'd4800}, packed like HALF_PERIOD_TABLE. Effect length in samples.
- PREEMPT, 1, 1: a strictly higher-priority trigger aborts the current effect; 0: it waits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sfx_trigger  in  NUM_SFX  one-cycle request pulses, one bit per effect
- mute  in  1  forces output samples to 0 while playback timing continues
- audio_out_allowed  in  1  codec FIFO has space
- write_audio_out  out  1  sample-write strobe to codec
- left_channel_audio_out  out  SAMPLE_W  signed sample
- right_channel_audio_out  out  SAMPLE_W  identical to left
- busy  out  1  high in LOAD or PLAY
- active_id  out  clog2(NUM_SFX)  id being played; 0 when idle

Behaviour:
- Reset (synchronous, clk edge with reset=1): state IDLE, pending=0, counters=0, polarity=1, all outputs 0. Reset mid-effect aborts it the same edge and drops all pending requests.
- Pending register: pending[i] is set on the edge after sfx_trigger[i]=1. It is cleared when id i is loaded. Set and clear on the same edge: set wins.
- Streaming: write_audio_out = audio_out_allowed, combinational, in every state. The codec is always fed and zeros are written when silent. A sample is "consumed" on any cycle with write_audio_out=1.
- Sample value: +AMPLITUDE if state==PLAY, polarity=1 and mute=0. -AMPLITUDE if state==PLAY, polarity=0 and mute=0. Otherwise 0. Left and right are always equal.
- FSM:
  - IDLE: if pending!=0, go to LOAD.
  - LOAD: select the lowest set pending id. Latch half=max(table,1) and dur=max(table,1); set phase=0, polarity=1; clear that pending bit; set active_id. Go to PLAY.
  - PLAY, each consumed sample:
    - phase==half-1: toggle polarity and set phase=0; otherwise phase+1.
    - dur==1: the effect ends; go to LOAD if pending (excluding the bit set this edge is fine) is nonzero, else IDLE. Otherwise dur-1.
  - PLAY with no consumed sample: counters hold.
- Preemption (PREEMPT=1): in PLAY, a pending bit with index < active_id forces LOAD on the next edge. The current effect is discarded, not resumed. A retrigger of the active id (or any lower-priority id) only sets pending, so the effect replays afterwards.
- Latency: trigger in cycle t gives pending at t+1, LOAD at t+2, PLAY at t+3. The first +AMPLITUDE sample is presented at t+3.
- Effect length is exactly dur consumed samples, regardless of audio_out_allowed gaps.

Decomposition:
- Package game_sound_pkg: FSM state encoding (IDLE, LOAD, PLAY), default table constants, AMPLITUDE default, helper function for the priority-encoder index.
- Sub-module sfx_tone_gen: loadable phase counter, polarity flop and duration down-counter. Inputs are load, half, dur and advance; outputs are polarity and done.
- The top level holds pending, the arbiter and the FSM.

Test Plan:
- Reset then sfx_trigger=4'b0001, allowed tied high -> PLAY at cycle 3. Output is 24 samples of +0x100000 then 24 of -0x100000, repeating. Exactly 4800 nonzero samples, then zeros; busy falls.
- Triggers 4'b0010 and 4'b0001 in the same cycle -> id0 (4800 samples) plays first, then id1 (9600 samples, half-period 96) with a single LOAD cycle between them, no IDLE.
- PREEMPT=1: id1 playing, id0 pulse at sample 100 -> id1 aborts; id0 plays a full 4800 samples; id1 does not resume. PREEMPT=0 with the same stimulus -> id1 completes 9600 samples, then id0 plays.
- Id0 playing, audio_out_allowed toggled 1-0-1-0 -> write_audio_out mirrors it. Still exactly 4800 consumed nonzero samples; the phase is unchanged during gaps.
- mute=1 during id2 -> all samples 0 but busy stays high for exactly 2400 consumed samples. Reset asserted at sample 500 of id3 with id1 pending -> next edge IDLE, outputs 0, pending cleared, nothing plays afterwards.
- Override HALF_PERIOD_TABLE/DURATION_TABLE entry to 0 -> treated as 1: one +AMPLITUDE sample, then IDLE.

Source files
------------

// File: rtl/game_sound_pkg.sv
// Shared types, default tables and helpers for the whack-a-mole sound-effect engine.
package game_sound_pkg;

  // Sequencer FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  // Default effect set: id0 hit, id1 miss, id2 start, id3 game-over (id0 in LSBs).
  localparam int DEFAULT_NUM_SFX = 4;
  localparam int DEFAULT_CNT_W   = 16;
  localparam int DEFAULT_SAMPLE_W = 24;

  localparam logic [63:0] DEFAULT_HALF_PERIOD_TABLE = {16'd120, 16'd48, 16'd96, 16'd24};
  localparam logic [63:0] DEFAULT_DURATION_TABLE    = {16'd24000, 16'd2400, 16'd9600, 16'd4800};
  localparam logic [23:0] DEFAULT_AMPLITUDE         = 24'h100000;

  // Index of the lowest set bit (highest priority request); 0 when nothing is set.
  function automatic int lowest_set(input logic [31:0] req);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (req[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/game_sound_sequencer_tone.sv
// Square-wave timing core: half-period phase counter, polarity flop and
// duration down-counter. Everything advances only on consumed samples.
module sfx_tone_gen
  import game_sound_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] half,
  input  logic [CNT_W-1:0] dur,
  input  logic             advance,
  output logic             polarity,
  output logic             done
);

  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] dur_q;

  // Load clamps zero table entries to one; each consumed sample steps phase and duration.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_q   <= '0;
      phase_q  <= '0;
      dur_q    <= '0;
      polarity <= 1'b1;
    end else if (load) begin
      half_q   <= (half == '0) ? CNT_W'(1) : half;
      dur_q    <= (dur == '0) ? CNT_W'(1) : dur;
      phase_q  <= '0;
      polarity <= 1'b1;
    end else if (advance) begin
      if (phase_q == half_q - CNT_W'(1)) begin
        phase_q  <= '0;
        polarity <= ~polarity;
      end else begin
        phase_q <= phase_q + CNT_W'(1);
      end
      if (dur_q != '0) begin
        dur_q <= dur_q - CNT_W'(1);
      end
    end
  end

  // The sample currently presented is the last one of the effect.
  assign done = (dur_q == CNT_W'(1));

endmodule

// File: rtl/game_sound_sequencer.sv
// Sound-effect sequencer: latches trigger pulses, arbitrates by priority
// (id0 highest), plays one square-wave effect at a time and streams samples
// to the codec FIFO every cycle it has room, writing zeros when silent.
module game_sound_sequencer
  import game_sound_pkg::*;
#(
  parameter int                         NUM_SFX           = DEFAULT_NUM_SFX,
  parameter int                         SAMPLE_W          = DEFAULT_SAMPLE_W,
  parameter logic [SAMPLE_W-1:0]        AMPLITUDE         = SAMPLE_W'(DEFAULT_AMPLITUDE),
  parameter int                         CNT_W             = DEFAULT_CNT_W,
  parameter logic [NUM_SFX*CNT_W-1:0]   HALF_PERIOD_TABLE = DEFAULT_HALF_PERIOD_TABLE,
  parameter logic [NUM_SFX*CNT_W-1:0]   DURATION_TABLE    = DEFAULT_DURATION_TABLE,
  parameter bit                         PREEMPT           = 1'b1,
  localparam int                        ID_W              = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SFX-1:0]  sfx_trigger,
  input  logic                mute,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [SAMPLE_W-1:0] left_channel_audio_out,
  output logic [SAMPLE_W-1:0] right_channel_audio_out,
  output logic                busy,
  output logic [ID_W-1:0]     active_id
);

  localparam logic [SAMPLE_W-1:0] POS_SAMPLE = AMPLITUDE;
  localparam logic [SAMPLE_W-1:0] NEG_SAMPLE = ~AMPLITUDE + SAMPLE_W'(1);

  state_t             state;
  logic [NUM_SFX-1:0] pending;
  logic [NUM_SFX-1:0] load_mask;
  logic [NUM_SFX-1:0] higher_mask;
  logic [ID_W-1:0]    sel_id;
  logic [CNT_W-1:0]   sel_half;
  logic [CNT_W-1:0]   sel_dur;
  logic               load;
  logic               advance;
  logic               preempt;
  logic               tone_polarity;
  logic               tone_done;
  logic [SAMPLE_W-1:0] sample;

  // The codec is fed on every cycle it accepts data; consumed samples drive all timing.
  assign write_audio_out = audio_out_allowed;
  assign advance         = (state == ST_PLAY) && audio_out_allowed;
  assign load            = (state == ST_LOAD);

  // Arbiter: pick the highest-priority pending id, look up its table entries and flag preemption.
  always_comb begin
    sel_id      = ID_W'(lowest_set(32'(pending)));
    sel_half    = HALF_PERIOD_TABLE[int'(sel_id)*CNT_W +: CNT_W];
    sel_dur     = DURATION_TABLE[int'(sel_id)*CNT_W +: CNT_W];
    load_mask   = '0;
    higher_mask = '0;
    if (load) begin
      load_mask[sel_id] = 1'b1;
    end
    for (int i = 0; i < NUM_SFX; i++) begin
      higher_mask[i] = (i < int'(active_id));
    end
    preempt = PREEMPT && (state == ST_PLAY) && ((pending & higher_mask) != '0);
  end

  // Request latch: a trigger landing on the same edge as its clear must survive.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~load_mask) | sfx_trigger;
    end
  end

  // Sequencer FSM with registered busy/active_id.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      active_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending != '0) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          state     <= ST_PLAY;
          busy      <= 1'b1;
          active_id <= sel_id;
        end
        ST_PLAY: begin
          if (preempt) begin
            state <= ST_LOAD;
          end else if (advance && tone_done) begin
            if (pending != '0) begin
              state <= ST_LOAD;
            end else begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              active_id <= '0;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          active_id <= '0;
        end
      endcase
    end
  end

  sfx_tone_gen #(
    .CNT_W(CNT_W)
  ) u_tone (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .half     (sel_half),
    .dur      (sel_dur),
    .advance  (advance),
    .polarity (tone_polarity),
    .done     (tone_done)
  );

  // Sample mux: square wave only while playing and unmuted, silence otherwise.
  always_comb begin
    sample = '0;
    if ((state == ST_PLAY) && !mute) begin
      sample = tone_polarity ? POS_SAMPLE : NEG_SAMPLE;
    end
  end

  assign left_channel_audio_out  = sample;
  assign right_channel_audio_out = sample;

endmodule
